// File: rtl/ps2_host_tx_if.sv
// Command handshake plus open-drain PS/2 line controls for the host transmitter.
interface ps2_host_tx_if;
  localparam int unsigned DATA_W = 8;

  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              ps2_clk_in;
  logic              ps2_data_in;
  logic              ps2_clk_oe;
  logic              ps2_data_oe;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output tx_valid, tx_data, ps2_clk_in, ps2_data_in,
    input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err
  );

  modport slave (
    input  tx_valid, tx_data, ps2_clk_in, ps2_data_in,
    output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter sharing the open-drain lines with the mouse receiver.
// Optional PS2_TX_RETRY_EN: re-send the latched byte up to RETRY_MAX times before reporting err.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 15000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
`ifdef PS2_TX_RETRY_EN
  ,
  parameter int unsigned RETRY_MAX      = 2
`endif
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus
);
  localparam int unsigned INH_W   = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned SHIFT_W = 9;
  localparam int unsigned FILT_W  = 4;
`ifdef PS2_TX_RETRY_EN
  localparam int unsigned RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_FAIL
  } state_t;

  state_t               r_state, w_state_n;
  logic [1:0]           r_clk_sync, r_data_sync;
  logic [FILT_W-1:0]    r_clk_hist;
  logic                 r_clk_filt;
  logic                 w_fall;
  logic [SHIFT_W-1:0]   r_shift, w_shift_n;
  logic [BIT_W-1:0]     r_bitcnt, w_bitcnt_n;
  logic [INH_W-1:0]     r_inh_cnt, w_inh_cnt_n;
  logic [TO_W-1:0]      r_to_cnt, w_to_cnt_n;
  logic                 r_data_oe, w_data_oe_n;
  logic                 r_clk_oe, r_tx_ready, r_busy, r_done, r_err;
  logic                 w_fail;
`ifdef PS2_TX_RETRY_EN
  logic [RETRY_W-1:0]   r_retry_cnt, w_retry_n;
`endif

  // Synchronize both lines; clock level only moves when four samples agree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_hist  <= '1;
      r_clk_filt  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], bus.ps2_clk_in};
      r_data_sync <= {r_data_sync[0], bus.ps2_data_in};
      r_clk_hist  <= {r_clk_hist[FILT_W-2:0], r_clk_sync[1]};
      if (&r_clk_hist) begin
        r_clk_filt <= 1'b1;
      end else if (~|r_clk_hist) begin
        r_clk_filt <= 1'b0;
      end
    end
  end

  assign w_fall = r_clk_filt & ~|r_clk_hist;

  always_comb begin
    w_state_n   = r_state;
    w_shift_n   = r_shift;
    w_bitcnt_n  = r_bitcnt;
    w_inh_cnt_n = '0;
    w_to_cnt_n  = '0;
    w_data_oe_n = r_data_oe;
    w_fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    w_retry_n   = r_retry_cnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (bus.tx_valid && r_tx_ready) begin
          w_shift_n = {~^bus.tx_data, bus.tx_data};
          w_state_n = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          w_retry_n = '0;
`endif
        end
      end
      S_INHIBIT: begin
        if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          w_state_n = S_REQ;
        end else begin
          w_inh_cnt_n = r_inh_cnt + INH_W'(1);
        end
      end
      S_REQ: begin
        w_bitcnt_n = '0;
        w_state_n  = S_SEND;
      end
      // Shifting in ones makes the tenth fall release the line as the stop bit.
      S_SEND: begin
        if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_fail = 1'b1;
        end else begin
          w_to_cnt_n = r_to_cnt + TO_W'(1);
          if (w_fall) begin
            w_data_oe_n = ~r_shift[0];
            w_shift_n   = {1'b1, r_shift[SHIFT_W-1:1]};
            w_bitcnt_n  = r_bitcnt + BIT_W'(1);
            if (r_bitcnt == BIT_W'(9)) begin
              w_state_n = S_ACK;
            end
          end
        end
      end
      S_ACK: begin
        if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_fail = 1'b1;
        end else begin
          w_to_cnt_n = r_to_cnt + TO_W'(1);
          if (w_fall) begin
            if (r_data_sync[1]) begin
              w_fail = 1'b1;
            end else begin
              w_state_n = S_WAIT_IDLE;
            end
          end
        end
      end
      S_WAIT_IDLE: begin
        if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_fail = 1'b1;
        end else begin
          w_to_cnt_n = r_to_cnt + TO_W'(1);
          if (r_clk_sync[1] && r_data_sync[1]) begin
            w_state_n = S_DONE;
          end
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      S_FAIL:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase

    if (w_fail) begin
`ifdef PS2_TX_RETRY_EN
      if (r_retry_cnt < RETRY_W'(RETRY_MAX)) begin
        w_retry_n = r_retry_cnt + RETRY_W'(1);
        w_state_n = S_INHIBIT;
      end else begin
        w_state_n = S_FAIL;
      end
`else
      w_state_n = S_FAIL;
`endif
    end

    // Data line is owned only while requesting and sending.
    if (w_state_n == S_REQ) begin
      w_data_oe_n = 1'b1;
    end else if (w_state_n != S_SEND) begin
      w_data_oe_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_inh_cnt   <= '0;
      r_to_cnt    <= '0;
      r_data_oe   <= 1'b0;
      r_clk_oe    <= 1'b0;
      r_tx_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      r_retry_cnt <= '0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_shift     <= w_shift_n;
      r_bitcnt    <= w_bitcnt_n;
      r_inh_cnt   <= w_inh_cnt_n;
      r_to_cnt    <= w_to_cnt_n;
      r_data_oe   <= w_data_oe_n;
      r_clk_oe    <= (w_state_n == S_INHIBIT) || (w_state_n == S_REQ);
      r_tx_ready  <= (w_state_n == S_IDLE);
      r_busy      <= (w_state_n != S_IDLE);
      r_done      <= (w_state_n == S_DONE);
      r_err       <= (w_state_n == S_FAIL);
`ifdef PS2_TX_RETRY_EN
      r_retry_cnt <= w_retry_n;
`endif
    end
  end

  assign bus.tx_ready    = r_tx_ready;
  assign bus.ps2_clk_oe  = r_clk_oe;
  assign bus.ps2_data_oe = r_data_oe;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed and randomized bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  localparam int unsigned INH  = 50;
  localparam int unsigned TMO  = 3000;
  localparam int unsigned HALF = 25;
`ifdef PS2_TX_RETRY_EN
  localparam int unsigned ATTEMPTS = 3;
`else
  localparam int unsigned ATTEMPTS = 1;
`endif

  logic clk;
  logic rst_n;
  logic dev_clk;
  logic dev_data;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_both = 0;
  int n_inh  = 0;
  int unsigned run = 0;
  int unsigned last_inh = 0;

  ps2_host_tx_if bus ();

  // Open-drain wiring: a line is high only if neither side pulls it low.
  assign bus.ps2_clk_in  = dev_clk & ~bus.ps2_clk_oe;
  assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1) n_done++;
    if (bus.err === 1'b1) n_err++;
    if (bus.done === 1'b1 && bus.err === 1'b1) n_both++;
    if (bus.ps2_clk_oe === 1'b1 && bus.ps2_data_oe === 1'b0) begin
      run++;
    end else if (run != 0) begin
      last_inh = run;
      n_inh++;
      run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line levels for one frame: data LSB first, odd parity, stop bit.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic offer(input logic [7:0] b);
    @(negedge clk);
    check("ready_before_accept", 32'(bus.tx_ready), 32'd1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
    check("accept_state", 32'({bus.tx_ready, bus.busy, bus.ps2_clk_oe, bus.ps2_data_oe}), 32'b0110);
  endtask

  // Offers a competing byte while busy, then expects REQ and the clock release.
  task automatic host_phase();
    int unsigned n = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'($urandom);
    while (!(bus.ps2_clk_oe === 1'b1 && bus.ps2_data_oe === 1'b1) && n < INH + 100) begin
      @(negedge clk);
      n++;
    end
    check("req_lines", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'b11);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("clk_release", 32'({bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy}), 32'b011);
    check("inhibit_cycles", last_inh, INH);
  endtask

  task automatic device(input bit ack, input bit glitch, output logic [9:0] bits);
    bits = '0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (8) @(negedge clk);
      if (glitch) begin
        dev_clk = 1'b0;
        @(negedge clk);
        dev_clk = 1'b1;
      end
      repeat (4) @(negedge clk);
      bits[k] = bus.ps2_data_in;
      repeat (HALF - 12) @(negedge clk);
    end
    dev_data = ~ack;
    dev_clk  = 1'b0;
    for (int i = 0; i < int'(HALF); i++) begin
      @(negedge clk);
      if (bus.err === 1'b1 || bus.ps2_clk_oe === 1'b1) break;
    end
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic wait_outcome(input int unsigned limit, output int unsigned n, output logic [2:0] dec);
    n = 0;
    while (!(bus.done === 1'b1 || bus.err === 1'b1 || bus.ps2_clk_oe === 1'b1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    dec = {bus.done, bus.err, bus.ps2_clk_oe};
  endtask

  task automatic run_byte(input logic [7:0] b, input bit ack, input bit glitch);
    int d0, e0, i0;
    int unsigned tries, n;
    logic [9:0] bits;
    logic [2:0] dec;
    d0 = n_done; e0 = n_err; i0 = n_inh;
    tries = ack ? 1 : ATTEMPTS;
    offer(b);
    for (int unsigned a = 0; a < tries; a++) begin
      host_phase();
      device(ack, glitch, bits);
      check("frame_bits", 32'(bits), 32'(frame_of(b)));
      wait_outcome(60, n, dec);
      if (ack) begin
        check("outcome_done", 32'(dec), 32'b100);
      end else if (a + 1 < tries) begin
        check("outcome_retry", 32'({dec, bus.busy}), 32'b0011);
      end else begin
        check("outcome_err", 32'(dec), 32'b010);
        check("err_lines_released", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'b00);
      end
    end
    @(negedge clk);
    check("back_to_idle", 32'({bus.tx_ready, bus.busy, bus.done, bus.err}), 32'b1000);
    check("done_count", 32'(n_done - d0), 32'(ack));
    check("err_count", 32'(n_err - e0), 32'(!ack));
    check("inhibit_phases", 32'(n_inh - i0), tries);
  endtask

  initial begin
    int d0, e0, i0;
    int unsigned n;
    logic [2:0] dec;

    rst_n        = 1'b0;
    dev_clk      = 1'b1;
    dev_data     = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({bus.tx_ready, bus.busy, bus.ps2_clk_oe, bus.ps2_data_oe, bus.done, bus.err}),
          32'b100000);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    run_byte(8'hF4, 1'b1, 1'b0);
    run_byte(8'hFF, 1'b1, 1'b0);
    repeat (3) run_byte(8'($urandom), 1'b1, 1'b0);
    run_byte(8'($urandom), 1'b1, 1'b1);
    run_byte(8'hF3, 1'b0, 1'b0);

    // Silent device: only the timeout can end each attempt.
    d0 = n_done; e0 = n_err; i0 = n_inh;
    offer(8'($urandom));
    for (int unsigned a = 0; a < ATTEMPTS; a++) begin
      host_phase();
      wait_outcome(TMO + 20, n, dec);
      check("timeout_cycles", n, TMO);
      if (a + 1 < ATTEMPTS) check("timeout_retry", 32'({dec, bus.busy}), 32'b0011);
      else check("timeout_err", 32'({dec, bus.ps2_data_oe}), 32'b0100);
    end
    @(negedge clk);
    check("timeout_idle", 32'({bus.tx_ready, bus.busy}), 32'b10);
    check("timeout_err_count", 32'(n_err - e0), 32'd1);
    check("timeout_done_count", 32'(n_done - d0), 32'd0);
    check("timeout_inhibit_phases", 32'(n_inh - i0), ATTEMPTS);

    // Reset while bit 4 (a zero, so data is pulled low) is on the line.
    d0 = n_done; e0 = n_err;
    offer(8'hE5);
    host_phase();
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    check("bit4_driven", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'b01);
    #2 rst_n = 1'b0;
    #1 check("reset_async_release", 32'({bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy}), 32'b000);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("after_reset_idle", 32'({bus.tx_ready, bus.busy, bus.done, bus.err}), 32'b1000);
    check("after_reset_no_pulse", 32'({n_done - d0, n_err - e0}), 64'd0);

    run_byte(8'($urandom), 1'b1, 1'b0);
    check("done_err_exclusive", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. The mouse controller only receives device-to-host packets; this block sends command bytes the other way, e.g. 0xFF reset, 0xF4 enable data reporting, 0xF3 set sample rate.
- Sits beside the mouse receiver on the shared PS2_CLK/PS2_DATA open-drain lines. It asserts `busy` so the receiver ignores line activity during a host transfer.

Parameters:
- INHIBIT_CYCLES, 15000: clk cycles PS2_CLK is held low before the request (150 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum clk cycles from clock release to ACK completion (20 ms).
- RETRY_MAX, 2: automatic re-sends after a failure (used only with the optional feature).

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous active-low reset
- tx_valid  in  1  command byte offered
- tx_data  in  8  command byte
- tx_ready  out  1  high only in IDLE; a byte is accepted when tx_valid && tx_ready
- ps2_clk_in  in  1  raw PS2_CLK line level
- ps2_data_in  in  1  raw PS2_DATA line level
- ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release (high-Z)
- ps2_data_oe  out  1  1 = drive PS2_DATA low, 0 = release
- busy  out  1  transfer in progress (any state except IDLE)
- done  out  1  one-cycle pulse: byte acknowledged by device
- err  out  1  one-cycle pulse: timeout or missing ACK

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; tx_ready=1; ps2_clk_oe=0; ps2_data_oe=0; busy=0; done=0; err=0. All counters cleared.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer.
  - The synchronized clock feeds a 4-sample shift filter; the filtered level changes only when all 4 samples agree.
  - fall = filtered clock changes 1->0, one-cycle strobe.
- Accept: in IDLE, on tx_valid && tx_ready:
  - latch shift = {parity, tx_data}, parity = ~^tx_data (odd parity);
  - go to INHIBIT next cycle.
  - tx_ready falls the cycle after accept.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
- REQ: ps2_clk_oe=1 and ps2_data_oe=1 (start bit 0) for 1 cycle. Then ps2_clk_oe=0, keep ps2_data_oe=1, clear bit counter (4 bit) and timeout counter, go to SEND.
- SEND: on each fall, with bitcnt counting 0..9:
  - bitcnt 0..8: ps2_data_oe <= ~shift[bitcnt]. Bits 0..7 are data LSB first; bit 8 is parity.
  - bitcnt 9: ps2_data_oe <= 0 (stop bit, line released).
  - bitcnt increments after each fall; when it reaches 10, go to ACK.
  - ps2_data_oe only ever changes on fall strobes.
- ACK: on the next fall, sample filtered-sync data:
  - 0 -> WAIT_IDLE;
  - 1 -> FAIL.
- WAIT_IDLE: wait until synchronized clk=1 and data=1 on the same cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- FAIL: ps2_clk_oe=0, ps2_data_oe=0, err=1 for one cycle, then IDLE.
- Timeout:
  - The timeout counter runs in SEND, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES-1 in any of these, go to FAIL.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Line ownership: ps2_clk_oe is 1 only in INHIBIT and REQ. ps2_data_oe is 1 only in REQ and SEND.
- Ignored inputs: tx_valid and tx_data are ignored while busy; no queuing. A fall seen in IDLE, INHIBIT or REQ is ignored.
- Reset mid-transfer: both lines released immediately (asynchronously); no done or err pulse.
- done and err are never asserted on the same cycle.

Optional Feature:
- PS2_TX_RETRY_EN defined:
  - On a FAIL condition with retry_cnt < RETRY_MAX: increment retry_cnt, re-enter INHIBIT with the same latched byte, no err pulse.
  - err pulses only after RETRY_MAX retries also fail.
  - retry_cnt clears on accept.
  - busy stays 1 throughout the retries.
- Undefined: the first FAIL pulses err and returns to IDLE; no retry_cnt logic is present.

Test Plan:
- Send 0xF4, device model clocks 11 falls at 12.5 kHz and ACKs low → ps2_clk_oe high 15000 cycles; data bits on line 0,0,1,0,1,1,1,1 (LSB first); parity 0 (0xF4 has five 1s); done pulses once; err stays 0.
- Send 0xFF → parity bit 1 (line released); ACK present → done pulses.
- Device omits ACK (data stays high at 11th fall) → err pulses once; both oe outputs 0; tx_ready returns 1 the next cycle.
- Device never clocks after REQ → err pulses 2000000 cycles after clock release (macro undefined). With PS2_TX_RETRY_EN defined: exactly 3 INHIBIT phases, then one err pulse.
- 1-cycle glitches on ps2_clk_in during SEND → no extra bits shifted; the byte still completes correctly.
- rst asserted mid-SEND at bit 4 → ps2_clk_oe and ps2_data_oe drop within the same cycle; after reset release, tx_ready=1 and neither done nor err has pulsed.
